// File: rtl/x_stages_pkg.sv
// Shared constants for the X-stage datapath: default modulus, datapath
// widths and the Barrett multiplier derivation.
package x_stages_pkg;

  localparam int unsigned DIN_W  = 64;  // multiplier product width
  localparam int unsigned LO_W   = 34;  // low product slice / remainder width
  localparam int unsigned HI_W   = 33;  // high product slice / quotient width
  localparam int unsigned DOUT_W = 32;  // residue width

  // 3*2^30 + 1
  localparam logic [31:0] Q_DEFAULT = 32'd3221225473;

  // Barrett multiplier M = floor(2^64 / q), 33 bits for 2^31 < q < 2^32.
  function automatic logic [32:0] barrett_m(input logic [31:0] q);
    logic [64:0] num;
    num = 65'd1 << 64;
    return 33'(num / {33'd0, q});
  endfunction

endpackage

// File: rtl/x_stages_barrett_mulstage.sv
// Registered unsigned multiply keeping an OUT_W-bit window of the product
// starting at bit LSB. Holds on ce low, clears on synchronous reset.
module x_stages_barrett_mulstage #(
  parameter int unsigned A_W   = 33,
  parameter int unsigned B_W   = 33,
  parameter int unsigned LSB   = 0,
  parameter int unsigned OUT_W = 34
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ce,
  input  logic [A_W-1:0]   a,
  input  logic [B_W-1:0]   b,
  output logic [OUT_W-1:0] p
);

  logic [A_W+B_W-1:0] prod;
  logic [OUT_W-1:0]   p_d;
  logic [OUT_W-1:0]   p_q;

  assign prod = a * b;
  assign p_d  = OUT_W'(prod >> LSB);

  // Product window register, stalls with the rest of the pipeline.
  always_ff @(posedge clk) begin
    if (reset) begin
      p_q <= '0;
    end else if (ce) begin
      p_q <= p_d;
    end
  end

  assign p = p_q;

endmodule

// File: rtl/x_stages_barrett_reduce.sv
// Four-stage Barrett reducer: 64-bit product -> product mod Q.
//   1: split the product into x_hi (bits 63:31) and x_lo (bits 33:0)
//   2: qh = (x_hi * M) >> 33
//   3: low 34 bits of qh * Q, alongside x_lo
//   4: r = x_lo - qh*Q (mod 2^34), then one of r, r-Q, r-2Q
// The subtract is folded into the last stage so each multiply can own its
// own register stage; latency remains four enabled edges.
module x_stages_barrett_reduce
  import x_stages_pkg::*;
#(
  parameter logic [31:0] Q          = Q_DEFAULT,
  parameter int unsigned DIN_WIDTH  = DIN_W,
  parameter int unsigned DOUT_WIDTH = DOUT_W
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [DIN_WIDTH-1:0]  din,
  output logic                  out_valid,
  output logic [DOUT_WIDTH-1:0] dout
);

  localparam int unsigned NUM_STAGES = 4;
  localparam logic [HI_W-1:0] M_CONST = barrett_m(Q);
  localparam logic [LO_W-1:0] Q_EXT   = {2'b00, Q};
  localparam logic [LO_W-1:0] TWO_Q   = {1'b0, Q, 1'b0};

  logic [HI_W-1:0]       x_hi_q;
  logic [LO_W-1:0]       x_lo_q1;
  logic [LO_W-1:0]       x_lo_q2;
  logic [LO_W-1:0]       x_lo_q3;
  logic [HI_W-1:0]       qh;
  logic [LO_W-1:0]       qq_lo;
  logic [LO_W-1:0]       r;
  logic                  ge_2q;
  logic                  ge_q;
  logic [DOUT_WIDTH-1:0] dout_d;
  logic [DOUT_WIDTH-1:0] dout_q;
  logic [NUM_STAGES-1:0] valid_q;

  // Stage 1 and the x_lo delay line; data loads regardless of valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      x_hi_q  <= '0;
      x_lo_q1 <= '0;
      x_lo_q2 <= '0;
      x_lo_q3 <= '0;
    end else if (ce) begin
      x_hi_q  <= din[DIN_WIDTH-1 -: HI_W];
      x_lo_q1 <= din[LO_W-1:0];
      x_lo_q2 <= x_lo_q1;
      x_lo_q3 <= x_lo_q2;
    end
  end

  // Stage 2: quotient estimate, product bits [65:33].
  x_stages_barrett_mulstage #(
    .A_W  (HI_W),
    .B_W  (HI_W),
    .LSB  (HI_W),
    .OUT_W(HI_W)
  ) u_mul_qh (
    .clk  (clk),
    .reset(reset),
    .ce   (ce),
    .a    (x_hi_q),
    .b    (M_CONST),
    .p    (qh)
  );

  // Stage 3: only the low 34 bits of qh*Q matter since r < 3Q < 2^34.
  x_stages_barrett_mulstage #(
    .A_W  (HI_W),
    .B_W  (32),
    .LSB  (0),
    .OUT_W(LO_W)
  ) u_mul_qq (
    .clk  (clk),
    .reset(reset),
    .ce   (ce),
    .a    (qh),
    .b    (Q),
    .p    (qq_lo)
  );

  // Remainder wraps mod 2^34; the true value always lands in [0, 3Q).
  assign r     = x_lo_q3 - qq_lo;
  assign ge_2q = (r >= TWO_Q);
  assign ge_q  = (r >= Q_EXT);

  // Final correction: both comparisons resolve in parallel, one subtract wins.
  always_comb begin
    dout_d = DOUT_WIDTH'(r);
    if (ge_2q) begin
      dout_d = DOUT_WIDTH'(r - TWO_Q);
    end else if (ge_q) begin
      dout_d = DOUT_WIDTH'(r - Q_EXT);
    end
  end

  // Stage 4 output register.
  always_ff @(posedge clk) begin
    if (reset) begin
      dout_q <= '0;
    end else if (ce) begin
      dout_q <= dout_d;
    end
  end

  // Valid chain, one flop per stage, aligned with the data stages.
  for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_valid
    logic valid_d;
    if (gi == 0) begin : g_first
      assign valid_d = in_valid;
    end else begin : g_rest
      assign valid_d = valid_q[gi-1];
    end

    // Advance this stage's valid bit on enabled edges.
    always_ff @(posedge clk) begin
      if (reset) begin
        valid_q[gi] <= 1'b0;
      end else if (ce) begin
        valid_q[gi] <= valid_d;
      end
    end
  end

  assign out_valid = valid_q[NUM_STAGES-1];
  assign dout      = dout_q;

endmodule

// File: tb/tb_x_stages_barrett_reduce.sv
// Bench for x_stages_barrett_reduce: a latency-queue reference model checked
// every cycle, plus directed literal cases.
module tb_x_stages_barrett_reduce;

  localparam longint unsigned QL = 64'd3221225473;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ce = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] din = '0;
  logic        out_valid;
  logic [31:0] dout;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;
  int hit2q  = 0;

  typedef struct packed {
    logic        v;
    logic [31:0] d;
  } ent_t;

  ent_t inflight[$];
  ent_t exp_out = '0;

  always #5 clk = ~clk;

  x_stages_barrett_reduce dut (
    .clk      (clk),
    .reset    (reset),
    .ce       (ce),
    .in_valid (in_valid),
    .din      (din),
    .out_valid(out_valid),
    .dout     (dout)
  );

  function automatic logic [31:0] ref_mod(input logic [63:0] x);
    return 32'(x % QL);
  endfunction

  // Reference: every enabled edge admits one sample and releases the one
  // admitted three enabled edges earlier; reset empties the pipe to zeros.
  always @(posedge clk) begin
    ent_t e;
    if (reset) begin
      inflight = {};
      for (int i = 0; i < 3; i++) inflight.push_back('0);
      exp_out = '0;
    end else if (ce) begin
      e.v = in_valid;
      e.d = ref_mod(din);
      inflight.push_back(e);
      exp_out = inflight.pop_front();
      if (dut.valid_q[2] && dut.ge_2q) hit2q++;
    end
    #1;
    if (chk_en) begin
      checks++;
      if (out_valid !== exp_out.v || dout !== exp_out.d) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t got out_valid=%0b dout=%0d want out_valid=%0b dout=%0d",
                 $time, out_valid, dout, exp_out.v, exp_out.d);
      end
      if (out_valid === 1'b1 && dout >= 32'(QL)) begin
        errors++;
        $display("FAIL range t=%0t got dout=%0d want < %0d", $time, dout, QL);
      end
    end
  end

  task automatic check(input string name, input longint unsigned got, input longint unsigned want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  // One-cycle pulse, then measure latency and the residue against a literal.
  task automatic check_lit(input string name, input logic [63:0] x, input logic [31:0] want);
    int lat;
    @(negedge clk);
    in_valid = 1'b1;
    din      = x;
    @(negedge clk);
    in_valid = 1'b0;
    din      = {$urandom, $urandom};
    lat = 1;
    while (out_valid !== 1'b1 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({name, "_lat"}, lat, 4);
    check(name, dout, want);
    $display("lit %s din=%0d dout=%0d latency=%0d", name, x, dout, lat);
    repeat (5) @(negedge clk);
  endtask

  initial begin
    int nval;
    logic [31:0] a, b;
    logic        s_v;
    logic [31:0] s_d;
    logic [31:0] got[$];

    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk_en = 1'b1;
    @(negedge clk);
    check("reset_valid", out_valid, 0);
    check("reset_dout", dout, 0);

    check_lit("zero", 64'd0, 32'd0);
    check_lit("q", 64'd3221225473, 32'd0);
    check_lit("q_minus_1", 64'd3221225472, 32'd3221225472);
    check_lit("q1_sq", 64'd10376293541461622784, 32'd1);
    check_lit("all_ones", 64'hFFFF_FFFF_FFFF_FFFF, 32'd1789569708);

    // Streaming products a*b with a,b < Q.
    nval = 0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) nval++;
      a = $urandom_range(32'd3221225472);
      b = $urandom_range(32'd3221225472);
      in_valid = 1'b1;
      din      = {32'd0, a} * {32'd0, b};
    end
    @(negedge clk);
    if (out_valid === 1'b1) nval++;
    in_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) nval++;
    end
    check("stream_count", nval, 1000);
    $display("stream products=1000 valid_outputs=%0d", nval);

    // Stall with two samples in flight.
    @(negedge clk);
    in_valid = 1'b1;
    din      = 64'd3221225478;    // Q+5
    @(negedge clk);
    din      = 64'd6442450953;    // 2Q+7
    @(negedge clk);
    in_valid = 1'b0;
    din      = 64'd12345;
    ce       = 1'b0;
    s_v = out_valid;
    s_d = dout;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, s_v);
      check("stall_dout", dout, s_d);
    end
    ce = 1'b1;
    got = {};
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) got.push_back(dout);
    end
    check("stall_count", got.size(), 2);
    if (got.size() == 2) begin
      check("stall_first", got[0], 5);
      check("stall_second", got[1], 7);
    end
    $display("stall outputs=%0d", got.size());

    // Reset mid-stream with ce low; the sample offered with reset is dropped.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      din      = 64'd1000 + 64'(i);
    end
    @(negedge clk);
    din   = 64'd77;
    ce    = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    reset    = 1'b0;
    ce       = 1'b1;
    in_valid = 1'b0;
    check("midreset_valid", out_valid, 0);
    check("midreset_dout", dout, 0);
    nval = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid === 1'b1) nval++;
    end
    check("midreset_no_output", nval, 0);
    $display("midreset leaked_outputs=%0d", nval);

    // Random full-range 64-bit inputs, including values near 2^64.
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(7) != 0);
      if (i % 16 == 0) din = 64'hFFFF_FFFF_FFFF_FFFF - 64'($urandom);
      else             din = {$urandom, $urandom};
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (hit2q == 0) begin
      errors++;
      $display("FAIL corr_2q_hit got=%0d want>0", hit2q);
    end
    $display("random samples=10000 corr_2q_hits=%0d", hit2q);

    chk_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/x_stages_barrett_reduce.md
# x_stages_barrett_reduce

Pipelined Barrett modular reducer for the X-stage butterfly datapath. It sits directly downstream of the 32×32→64 product multiplier. It takes the 64-bit unsigned product and returns the product mod q as a 32-bit residue in [0, q), with a fixed 4-cycle latency. A valid bit travels with the data, and the whole pipeline stalls on ce the same way the multiplier does.

## Interface
- Q, 3221225473, modulus (3·2^30+1); must satisfy 2^31 < Q < 2^32
- DIN_WIDTH, 64, product width from the multiplier
- DOUT_WIDTH, 32, residue width
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- ce  input  1  clock enable; when low, every pipeline register holds
- in_valid  input  1  din carries a product this cycle
- din  input  64  unsigned product, any value in [0, 2^64)
- out_valid  output  1  dout is a valid residue
- dout  output  32  din mod Q

## Operation
- Barrett constants, k=32:
  - M = floor(2^64 / Q) = 5726623059 (0x1_5555_5553, 33 bits), computed as a localparam from Q.
  - Remainder of 2^64 / Q is 1789569709.
- Stage 1, register:
  - x_hi = din[63:31] (33 bits)
  - x_lo = din[33:0] (34 bits)
  - v1 = in_valid
- Stage 2, register:
  - qh = (x_hi * M) >> 33; the full product is 66 bits, qh is kept as 33 bits.
  - Pass x_lo; v2 = v1.
- Stage 3, register:
  - r = x_lo − (qh * Q)[33:0], computed modulo 2^34.
  - Guaranteed 0 ≤ r < 3Q < 2^34, so no sign bit is needed.
  - v3 = v2.
- Stage 4, register:
  - If r ≥ 2Q: dout = r − 2Q.
  - Else if r ≥ Q: dout = r − Q.
  - Else: dout = r.
  - Both comparisons are evaluated in parallel.
  - out_valid = v3.
- Correctness holds for every 64-bit input, not only inputs < Q². No saturation and no error flag.
- Data registers load whether or not valid is set (no gating on valid). Only the valid chain carries meaning.

## Timing
- Latency: 4 ce-high cycles.
  - A sample with in_valid=1 and ce=1 at edge N appears on dout/out_valid after edge N+3, i.e. it is visible in the cycle after the 4th enabled edge.
- Throughput: one sample per ce-high cycle, no bubbles.
- ce low:
  - All data and valid registers hold; dout and out_valid are frozen.
  - Samples presented while ce=0 are ignored. The upstream multiplier is held by the same ce.
- reset:
  - On an edge with reset=1, all valid bits (v1, v2, v3, out_valid) and all data registers clear to 0, so dout=0.
  - reset takes priority over ce; reset clears even when ce=0.
- Reset mid-stream: all in-flight samples are discarded. out_valid stays 0 until 4 enabled edges after the first new in_valid.
- Simultaneous in_valid with reset: the sample is dropped.
- Outputs leave reset as out_valid=0, dout=0.

## Structure
- Shared package x_stages_pkg holds:
  - Q_DEFAULT, the M derivation function, and the widths 64/34/33/32.
  - These are reused by the butterfly add/sub stage and the multiplier wrapper.
- One sub-module, x_stages_barrett_mulstage: a registered unsigned A×B with ce and synchronous reset. It is instantiated twice:
  - x_hi×M, keeping bits [65:33].
  - qh×Q, keeping the low 34 bits.
- The top level handles the x_lo delay, the subtract, the conditional correction, and the valid chain.

## Test plan
- Boundary inputs, reset released, ce=1, one-cycle in_valid pulse each:
  - din=0 → dout=0
  - din=Q → 0
  - din=Q−1 → 3221225472
  - Each with out_valid high exactly 4 cycles after its input.
- Maximum correction cases:
  - din = (Q−1)² = 10376293541461622784 → 1
  - din = 2^64−1 → 1789569708
  - Also check internally that the r ≥ 2Q correction path is hit.
- Streaming: 1000 back-to-back random products a·b with a, b < Q → each dout equals the reference a·b mod Q, in order, with out_valid continuous.
- Stall: drop ce for 3 cycles with 2 samples in flight → dout and out_valid frozen during the stall; the samples emerge in order after ce returns, with no duplicates or losses.
- Reset mid-stream: assert reset for 1 cycle while 3 samples are in flight (ce=0 on that edge) → out_valid=0 and dout=0 on the next cycle, and none of the 3 samples ever appears.
- Random 64-bit din, including values ≥ Q², 10k samples → dout = din mod Q and dout < Q always.
